sd_cmd_response_receiver: RTL and testbench

Deserialises the response token a card returns on the SD command line after the command stage has shifted out a command. The controller arms it with the response length and the CRC-check flag; it then waits up to the NCR window for a start bit and shifts in 48 or 136 bits. It checks the transmission bit, CRC7 and end bit, and presents the decoded fields and error flags to the controller with a one-cycle Done pulse.

---
 rtl/sd_cmd_response_receiver.sv | 214 +++++++++++++++++++++
 tb/tb_sd_cmd_response_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_response_receiver.sv
// SD command-line response receiver: waits within the NCR window for a start bit,
// shifts in a 48/136-bit response, checks tx bit, CRC7 and end bit, and reports the fields.
module sd_cmd_response_receiver #(
  parameter int unsigned gNcrCycles = 64
) (
  input  logic         Clk,
  input  logic         ResetAsync,
  input  logic         Cmd,
  input  logic         Arm,
  input  logic         LongResp,
  input  logic         CheckCrc,
  output logic         Busy,
  output logic         Done,
  output logic [5:0]   Index,
  output logic [31:0]  Arg,
  output logic [119:0] LongData,
  output logic [6:0]   RespCrc,
  output logic         TimeoutErr,
  output logic         TxBitErr,
  output logic         CrcErr,
  output logic         EndBitErr
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FRAME_W = 134;
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(47);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(135);
  localparam logic [CNT_W-1:0] NCR_LAST   = CNT_W'(gNcrCycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    SHIFT,
    FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [6:0]           crc_q, crc_d;
  logic                 long_q, long_d;
  logic                 chk_q, chk_d;
  logic                 to_q, to_d;
  logic                 txe_q, txe_d;
  logic                 ende_q, ende_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [5:0]           index_q, index_d;
  logic [31:0]          arg_q, arg_d;
  logic [119:0]         ldata_q, ldata_d;
  logic [6:0]           rcrc_q, rcrc_d;
  logic                 to_err_q, to_err_d;
  logic                 tx_err_q, tx_err_d;
  logic                 crc_err_q, crc_err_d;
  logic                 end_err_q, end_err_d;

  // Serial CRC7, generator x^7 + x^3 + 1, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    crc_d     = crc_q;
    long_d    = long_q;
    chk_d     = chk_q;
    to_d      = to_q;
    txe_d     = txe_q;
    ende_d    = ende_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    index_d   = index_q;
    arg_d     = arg_q;
    ldata_d   = ldata_q;
    rcrc_d    = rcrc_q;
    to_err_d  = to_err_q;
    tx_err_d  = tx_err_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;

    unique case (state_q)
      IDLE: begin
        // An Arm coinciding with the Done pulse is dropped.
        if (Arm && !done_q) begin
          long_d    = LongResp;
          chk_d     = CheckCrc;
          cnt_d     = '0;
          frame_d   = '0;
          crc_d     = '0;
          to_d      = 1'b0;
          txe_d     = 1'b0;
          ende_d    = 1'b0;
          busy_d    = 1'b1;
          index_d   = '0;
          arg_d     = '0;
          ldata_d   = '0;
          rcrc_d    = '0;
          to_err_d  = 1'b0;
          tx_err_d  = 1'b0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          state_d   = WAIT_START;
        end
      end

      WAIT_START: begin
        if (!Cmd) begin
          frame_d = {frame_q[FRAME_W-2:0], Cmd};
          cnt_d   = CNT_W'(1);
          if (!long_q) crc_d = crc7_step(crc_q, Cmd);
          state_d = SHIFT;
        end else if (cnt_q == NCR_LAST) begin
          to_d    = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        frame_d = {frame_q[FRAME_W-2:0], Cmd};
        cnt_d   = cnt_q + CNT_W'(1);
        // Short CRC spans ordinals 0..39; long CRC skips the 8-bit header (8..127).
        if (long_q ? (cnt_q >= CNT_W'(8) && cnt_q <= CNT_W'(127)) : (cnt_q <= CNT_W'(39)))
          crc_d = crc7_step(crc_q, Cmd);
        if (cnt_q == CNT_W'(1) && Cmd) txe_d = 1'b1;
        if (cnt_q == (long_q ? LONG_LAST : SHORT_LAST)) begin
          if (!Cmd) ende_d = 1'b1;
          state_d = FINISH;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (to_q) begin
          to_err_d = 1'b1;
        end else begin
          index_d   = long_q ? frame_q[133:128] : frame_q[45:40];
          arg_d     = long_q ? 32'd0 : frame_q[39:8];
          ldata_d   = long_q ? frame_q[127:8] : 120'd0;
          rcrc_d    = frame_q[7:1];
          tx_err_d  = txe_q;
          end_err_d = ende_q;
          crc_err_d = chk_q && (frame_q[7:1] != crc_q);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge ResetAsync) begin
    if (ResetAsync) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      crc_q     <= '0;
      long_q    <= 1'b0;
      chk_q     <= 1'b0;
      to_q      <= 1'b0;
      txe_q     <= 1'b0;
      ende_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      index_q   <= '0;
      arg_q     <= '0;
      ldata_q   <= '0;
      rcrc_q    <= '0;
      to_err_q  <= 1'b0;
      tx_err_q  <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      crc_q     <= crc_d;
      long_q    <= long_d;
      chk_q     <= chk_d;
      to_q      <= to_d;
      txe_q     <= txe_d;
      ende_q    <= ende_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      index_q   <= index_d;
      arg_q     <= arg_d;
      ldata_q   <= ldata_d;
      rcrc_q    <= rcrc_d;
      to_err_q  <= to_err_d;
      tx_err_q  <= tx_err_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Index      = index_q;
  assign Arg        = arg_q;
  assign LongData   = ldata_q;
  assign RespCrc    = rcrc_q;
  assign TimeoutErr = to_err_q;
  assign TxBitErr   = tx_err_q;
  assign CrcErr     = crc_err_q;
  assign EndBitErr  = end_err_q;

endmodule

// File: tb/tb_sd_cmd_response_receiver.sv
// Bench for sd_cmd_response_receiver: table vectors, random frames against a
// polynomial-division reference model, and reset / Arm-on-Done sequences.
module tb_sd_cmd_response_receiver;

  localparam int NCR = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd, arm, long_resp, check_crc;
  logic         busy, done;
  logic [5:0]   index;
  logic [31:0]  arg;
  logic [119:0] long_data;
  logic [6:0]   resp_crc;
  logic         to_err, tx_err, crc_err, end_err;

  int tests = 0;
  int fails = 0;

  sd_cmd_response_receiver #(.gNcrCycles(NCR)) dut (
    .Clk(clk), .ResetAsync(rst), .Cmd(cmd), .Arm(arm), .LongResp(long_resp),
    .CheckCrc(check_crc), .Busy(busy), .Done(done), .Index(index), .Arg(arg),
    .LongData(long_data), .RespCrc(resp_crc), .TimeoutErr(to_err),
    .TxBitErr(tx_err), .CrcErr(crc_err), .EndBitErr(end_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [119:0] ld;
    logic [6:0]   rc;
    bit           to, tx, ce, ee;
    int           done_at;
  } exp_t;

  typedef struct {
    string          nm;
    bit             lng, ck;
    int             d;
    logic [135:0]   frm;
    bit             to, tx, ce, ee;
    bit             arm_on_done;
  } vec_t;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [135:0] data, input int nbits);
    logic [142:0] r;
    r = {7'd0, data} << 7;
    for (int i = nbits + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic exp_t model(input bit lng, input bit ck, input int d, input logic [135:0] frm);
    exp_t e;
    int   len;
    len = lng ? 136 : 48;
    e = '{idx: '0, arg: '0, ld: '0, rc: '0, to: 1'b0, tx: 1'b0, ce: 1'b0, ee: 1'b0, done_at: 0};
    if (d >= NCR) begin
      e.to = 1'b1;
      e.done_at = NCR + 1;
    end else begin
      e.done_at = d + 1 + len;
      e.rc = frm[7:1];
      e.ee = !frm[0];
      if (lng) begin
        e.idx = frm[133:128];
        e.ld  = frm[127:8];
        e.tx  = frm[134];
        e.ce  = ck && (crc7_div({16'd0, frm[127:8]}, 120) != frm[7:1]);
      end else begin
        e.idx = frm[45:40];
        e.arg = frm[39:8];
        e.tx  = frm[46];
        e.ce  = ck && (crc7_div({88'd0, frm[47:8]}, 40) != frm[7:1]);
      end
    end
    return e;
  endfunction

  task automatic run_rx(input string nm, input bit lng, input bit ck, input int d,
                        input logic [135:0] frm, input exp_t e, input bit arm_on_done);
    int len, done_at;
    len = lng ? 136 : 48;
    @(negedge clk);
    arm = 1'b1; long_resp = lng; check_crc = ck; cmd = 1'b1;
    @(posedge clk); #1;
    chk({nm, ".busy_after_arm"}, 136'(busy), 136'(1'b1));
    done_at = -1;
    for (int j = 1; j <= 400 && done_at < 0; j++) begin
      @(negedge clk);
      arm = 1'b0;
      if (j <= d) cmd = 1'b1;
      else if (j - d - 1 < len) cmd = frm[len - 1 - (j - d - 1)];
      else cmd = 1'b1;
      @(posedge clk); #1;
      if (done) done_at = j;
    end
    chk({nm, ".done_at"}, 136'(done_at), 136'(e.done_at));
    chk({nm, ".index"}, 136'(index), 136'(e.idx));
    chk({nm, ".arg"}, 136'(arg), 136'(e.arg));
    chk({nm, ".longdata"}, 136'(long_data), 136'(e.ld));
    chk({nm, ".respcrc"}, 136'(resp_crc), 136'(e.rc));
    chk({nm, ".flags"}, 136'({to_err, tx_err, crc_err, end_err}), 136'({e.to, e.tx, e.ce, e.ee}));
    @(negedge clk);
    cmd = 1'b1;
    if (arm_on_done) begin
      arm = 1'b1; long_resp = 1'b0; check_crc = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, ".done_pulse"}, 136'({done, busy}), 136'(2'b00));
    if (arm_on_done) begin
      @(negedge clk);
      arm = 1'b0;
      @(posedge clk); #1;
      chk({nm, ".arm_on_done_ignored"}, 136'(busy), 136'(1'b0));
    end
  endtask

  vec_t         tbl[9];
  logic [119:0] cid;
  logic [39:0]  hdr;
  logic [135:0] frm;
  exp_t         e;

  initial begin
    rst = 1'b1; cmd = 1'b1; arm = 1'b0; long_resp = 1'b0; check_crc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 136'({busy, done, index, arg, long_data, resp_crc, to_err, tx_err, crc_err, end_err}), 136'(0));
    @(negedge clk);
    rst = 1'b0;

    cid = 120'h03_5344_5355_3136_4780_1234_5678_01;
    hdr = {1'b0, 1'b1, 6'h11, 32'h0000_0900};
    tbl[0] = '{"r1_ok",      0, 1, 4,   136'({40'h11_0000_0900, 7'h33, 1'b1}), 0, 0, 0, 0, 0};
    tbl[1] = '{"r1_crcflip", 0, 1, 4,   136'({40'h11_0000_0800, 7'h33, 1'b1}), 0, 0, 1, 0, 0};
    tbl[2] = '{"r1_flip_nochk", 0, 0, 4, 136'({40'h11_0000_0800, 7'h33, 1'b1}), 0, 0, 0, 0, 0};
    tbl[3] = '{"timeout",    0, 1, 200, 136'({40'h11_0000_0900, 7'h33, 1'b1}), 1, 0, 0, 0, 0};
    tbl[4] = '{"start_last", 0, 1, NCR - 1, 136'({40'h11_0000_0900, 7'h33, 1'b1}), 0, 0, 0, 0, 1};
    tbl[5] = '{"r2_cid",     1, 1, 2,   {2'b00, 6'h3F, cid, crc7_div({16'd0, cid}, 120), 1'b1}, 0, 0, 0, 0, 0};
    tbl[6] = '{"tx_end_err", 0, 1, 0,   136'({hdr, crc7_div({96'd0, hdr}, 40), 1'b0}), 0, 1, 0, 1, 0};
    tbl[7] = '{"r3_nochk",   0, 0, 9,   136'({40'h3F_80FF_8000, 7'h7F, 1'b1}), 0, 0, 0, 0, 0};
    tbl[8] = '{"r2_badcrc",  1, 1, 1,   {2'b00, 6'h3F, cid ^ 120'h1, crc7_div({16'd0, cid}, 120), 1'b1}, 0, 0, 1, 0, 0};

    for (int i = 0; i < 9; i++) begin
      e = model(tbl[i].lng, tbl[i].ck, tbl[i].d, tbl[i].frm);
      e.to = tbl[i].to; e.tx = tbl[i].tx; e.ce = tbl[i].ce; e.ee = tbl[i].ee;
      run_rx(tbl[i].nm, tbl[i].lng, tbl[i].ck, tbl[i].d, tbl[i].frm, e, tbl[i].arm_on_done);
    end

    // Reset in the middle of a short frame, then a clean reception.
    @(negedge clk);
    arm = 1'b1; long_resp = 1'b0; check_crc = 1'b1; cmd = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    cmd = tbl[0].frm[47];
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cmd = tbl[0].frm[47 - k];
    end
    #2 rst = 1'b1;
    #1;
    chk("midframe_reset", 136'({busy, done, index, arg, resp_crc, to_err, tx_err, crc_err, end_err}), 136'(0));
    chk("midframe_reset.ld", 136'(long_data), 136'(0));
    @(negedge clk);
    rst = 1'b0; cmd = 1'b1;
    run_rx("after_reset", 1'b0, 1'b1, 3, tbl[0].frm, model(1'b0, 1'b1, 3, tbl[0].frm), 1'b0);

    // Random frames, mostly well-formed, occasionally timing out.
    for (int n = 0; n < 24; n++) begin
      bit lng, ck, good;
      int d;
      lng  = 1'($urandom_range(0, 1));
      ck   = 1'($urandom_range(0, 1));
      good = ($urandom_range(0, 3) != 0);
      d    = $urandom_range(0, 70);
      frm  = 136'({$urandom, $urandom, $urandom, $urandom, $urandom});
      if (lng) begin
        frm[135] = 1'b0;
        if (good) begin
          frm[134] = 1'b0; frm[0] = 1'b1;
          frm[7:1] = crc7_div({16'd0, frm[127:8]}, 120);
        end
      end else begin
        frm[47] = 1'b0;
        if (good) begin
          frm[46] = 1'b0; frm[0] = 1'b1;
          frm[7:1] = crc7_div({88'd0, frm[47:8]}, 40);
        end
      end
      run_rx($sformatf("rand%0d", n), lng, ck, d, frm, model(lng, ck, d, frm), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
